qspi_sram_writer: RTL

Drains 32-bit camera words from one of the FPGA capture RAM banks and writes them to an external serial SRAM over a quad-SPI (SQI) bus. It sits directly downstream of the camera-to-RAM capture stage, on the RAM read port side. It produces the `qspi_tx_fin` flag reported in the RAM status word and drives the `QUAD_*` pads. It runs one burst per start request: command, 24-bit address, then N words.

---
 rtl/qspi_sram_writer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/qspi_sram_writer.sv
// Streams one burst of capture-RAM words to an external SQI SRAM:
// write opcode, 24-bit byte address, then len 32-bit words, MSB nibble first.
module qspi_sram_writer #(
    parameter int         ADDRWIDTH = 9,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 start_i,
    input  logic [23:0]          sram_addr_i,
    input  logic [ADDRWIDTH-1:0] ram_base_i,
    input  logic [ADDRWIDTH:0]   len_i,
    output logic [ADDRWIDTH-1:0] ram_rd_addr_o,
    input  logic [31:0]          ram_rd_data_i,
    output logic [3:0]           QUAD_Out_o,
    output logic                 QUAD_oe_o,
    output logic                 QUAD_nCE_o,
    output logic                 QUAD_SCK_o,
    output logic                 busy_o,
    output logic                 qspi_tx_fin
);

    localparam int CW = ADDRWIDTH + 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        FIN
    } state_t;

    state_t               state;
    logic [CW-1:0]        nib;
    logic [CW-1:0]        nib_nxt;
    logic [CW-1:0]        last_nib;
    logic [ADDRWIDTH:0]   len_q;
    logic [ADDRWIDTH:0]   issued;
    logic [27:0]          shreg;
    logic [31:0]          pf;
    logic                 req;
    logic                 cap;

    assign nib_nxt  = nib + CW'(1);
    assign last_nib = {len_q, 3'b111};

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state         <= IDLE;
            nib           <= '0;
            len_q         <= '0;
            issued        <= '0;
            shreg         <= '0;
            pf            <= '0;
            req           <= 1'b0;
            cap           <= 1'b0;
            ram_rd_addr_o <= '0;
            QUAD_Out_o    <= '0;
            QUAD_oe_o     <= 1'b0;
            QUAD_nCE_o    <= 1'b1;
            QUAD_SCK_o    <= 1'b0;
            busy_o        <= 1'b0;
            qspi_tx_fin   <= 1'b0;
        end else begin
            qspi_tx_fin <= 1'b0;
            // synchronous RAM: data for an issued address is valid two edges later
            req <= 1'b0;
            cap <= req;
            if (cap) begin
                pf <= ram_rd_data_i;
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            state         <= CMD;
                            len_q         <= len_i;
                            nib           <= '0;
                            QUAD_nCE_o    <= 1'b0;
                            QUAD_oe_o     <= 1'b1;
                            QUAD_SCK_o    <= 1'b0;
                            QUAD_Out_o    <= CMD_WRITE[7:4];
                            shreg         <= {CMD_WRITE[3:0], sram_addr_i};
                            ram_rd_addr_o <= ram_base_i;
                            issued        <= (ADDRWIDTH+1)'(1);
                            req           <= 1'b1;
                            busy_o        <= 1'b1;
                        end else begin
                            state       <= FIN;
                            qspi_tx_fin <= 1'b1;
                        end
                    end
                end
                CMD, ADDR, DATA: begin
                    if (!QUAD_SCK_o) begin
                        QUAD_SCK_o <= 1'b1;
                    end else begin
                        QUAD_SCK_o <= 1'b0;
                        if (nib == last_nib) begin
                            state       <= FIN;
                            qspi_tx_fin <= 1'b1;
                            busy_o      <= 1'b0;
                            QUAD_nCE_o  <= 1'b1;
                            QUAD_oe_o   <= 1'b0;
                            QUAD_Out_o  <= '0;
                            nib         <= '0;
                        end else begin
                            nib <= nib_nxt;
                            if (nib_nxt[2:0] == 3'd0) begin
                                // word boundary: consume prefetch, fetch the next word
                                state      <= DATA;
                                QUAD_Out_o <= pf[31:28];
                                shreg      <= pf[27:0];
                                if (issued != len_q) begin
                                    ram_rd_addr_o <= ram_rd_addr_o + ADDRWIDTH'(1);
                                    issued        <= issued + (ADDRWIDTH+1)'(1);
                                    req           <= 1'b1;
                                end
                            end else begin
                                QUAD_Out_o <= shreg[27:24];
                                shreg      <= {shreg[23:0], 4'h0};
                                if (nib_nxt == CW'(2)) begin
                                    state <= ADDR;
                                end
                            end
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
